// File: rtl/direction_input_ctrl.sv
// Button conditioner for the 2048 game: synchronise, debounce and turn one clean press into one fixed-length one-hot move pulse.
// Optional auto-repeat on a held button is built only when DIR_AUTOREPEAT_EN is defined.
module direction_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 4,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_raw,
  input  logic [1:0]  game_state,
  output logic [3:0]  direction,
  output logic [15:0] move_count,
  output logic        busy
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_MAX = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {READY, EMIT, WAIT_RELEASE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    btn_norm, sync1, sync2, deb;
  logic [DW-1:0] db_cnt [4];
  logic [3:0]    code_q, code_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          count_inc;
  logic          playing, single, multi;
  logic          rep_fire;

  assign btn_norm = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_norm;
      sync2 <= sync1;
    end
  end

  // The counter only advances while the synchronised level disagrees with the debounced one.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign playing = (game_state == 2'b01);
  assign single  = $onehot(deb);
  assign multi   = (deb != 4'b0000) && !single;

`ifdef DIR_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q;
  logic          rep_hold;

  // Any change of the debounced bits breaks the hold condition for at least one cycle, clearing the count.
  assign rep_hold = (state_q == WAIT_RELEASE) && single && (deb == code_q);
  assign rep_fire = rep_hold && (rep_q == REP_MAX) && playing;

  always_ff @(posedge clk) begin
    if (rst || !rep_hold) begin
      rep_q <= '0;
    end else if (rep_q != REP_MAX) begin
      rep_q <= rep_q + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pulse_d   = pulse_q;
    count_inc = 1'b0;
    case (state_q)
      READY: begin
        if (playing && single) begin
          state_d   = EMIT;
          code_d    = deb;
          pulse_d   = PULSE_MAX;
          count_inc = 1'b1;
        end else if (playing && multi) begin
          state_d = WAIT_RELEASE;
        end
      end
      // game2048 reports not_playing while it merges, so game_state is deliberately ignored here.
      EMIT: begin
        if (pulse_q == '0) state_d = WAIT_RELEASE;
        else               pulse_d = pulse_q - 1'b1;
      end
      WAIT_RELEASE: begin
        if (deb == 4'b0000) begin
          state_d = READY;
        end else if (rep_fire) begin
          state_d   = EMIT;
          pulse_d   = PULSE_MAX;
          count_inc = 1'b1;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= READY;
      code_q     <= '0;
      pulse_q    <= '0;
      move_count <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pulse_q <= pulse_d;
      if (count_inc && move_count != 16'hFFFF) move_count <= move_count + 16'd1;
    end
  end

  assign direction = (state_q == EMIT) ? code_q : 4'b0000;
  assign busy      = (state_q != READY);

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Directed bench for direction_input_ctrl with short debounce/pulse/repeat settings.
// The auto-repeat expectation follows DIR_AUTOREPEAT_EN as seen by this bench.
module tb_direction_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn_raw;
  logic [1:0]  game_state;
  logic [3:0]  direction;
  logic [15:0] move_count;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  direction_input_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .PULSE_CYCLES   (4),
    .REPEAT_CYCLES  (32),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .game_state(game_state),
    .direction (direction),
    .move_count(move_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    btn_raw    = 4'hF;
    game_state = 2'b01;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int nz;
    int rises;
    int first_rise;
    int second_rise;
    logic [3:0] prev_dir;

    // Reset state
    do_reset();
    check("reset_direction", 16'(direction), 16'h0);
    check("reset_move_count", move_count, 16'h0);
    check("reset_busy", 16'(busy), 16'h0);

    // Clean press: left, held for 20 cycles
    btn_raw = 4'b1011;
    tick(10);
    check("clean_before_pulse", 16'(direction), 16'h0);
    tick(1);
    check("clean_pulse_c1", 16'(direction), 16'h4);
    check("clean_move_count", move_count, 16'd1);
    check("clean_busy", 16'(busy), 16'h1);
    for (int i = 2; i <= 4; i++) begin
      tick(1);
      check($sformatf("clean_pulse_c%0d", i), 16'(direction), 16'h4);
    end
    tick(1);
    check("clean_after_pulse", 16'(direction), 16'h0);
    check("clean_wait_busy", 16'(busy), 16'h1);
    tick(5);
    btn_raw = 4'hF;
    tick(10);
    check("clean_release_busy_hold", 16'(busy), 16'h1);
    tick(1);
    check("clean_release_ready", 16'(busy), 16'h0);
    check("clean_final_count", move_count, 16'd1);

    // Bounce: bit 0 toggles every 3 cycles, then settles released
    do_reset();
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      btn_raw[0] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      if (direction != 4'b0000) nz++;
    end
    btn_raw = 4'hF;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (direction != 4'b0000) nz++;
    end
    check("bounce_no_pulse", 16'(nz), 16'd0);
    check("bounce_move_count", move_count, 16'd0);
    check("bounce_busy", 16'(busy), 16'h0);

    // Gating: press right while lost, then switch to playing
    do_reset();
    game_state = 2'b11;
    btn_raw    = 4'b0111;
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (direction != 4'b0000) nz++;
    end
    check("gate_no_pulse", 16'(nz), 16'd0);
    check("gate_busy", 16'(busy), 16'h0);
    check("gate_count_idle", move_count, 16'd0);
    game_state = 2'b01;
    tick(1);
    check("gate_pulse_c1", 16'(direction), 16'h8);
    check("gate_move_count", move_count, 16'd1);
    tick(3);
    check("gate_pulse_c4", 16'(direction), 16'h8);
    tick(1);
    check("gate_after_pulse", 16'(direction), 16'h0);
    btn_raw = 4'hF;
    tick(12);

    // Multi-press: top and right together
    do_reset();
    btn_raw = 4'b0110;
    nz = 0;
    for (int i = 0; i < 11; i++) begin
      tick(1);
      if (direction != 4'b0000) nz++;
    end
    check("multi_busy", 16'(busy), 16'h1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (direction != 4'b0000) nz++;
    end
    check("multi_no_pulse", 16'(nz), 16'd0);
    check("multi_busy_held", 16'(busy), 16'h1);
    btn_raw = 4'hF;
    tick(10);
    check("multi_release_busy_hold", 16'(busy), 16'h1);
    tick(1);
    check("multi_release_ready", 16'(busy), 16'h0);
    check("multi_move_count", move_count, 16'd0);

    // Mid-pulse game_state change: pulse must complete
    do_reset();
    btn_raw = 4'b1110;
    tick(11);
    check("midgs_pulse_c1", 16'(direction), 16'h1);
    game_state = 2'b00;
    for (int i = 2; i <= 4; i++) begin
      tick(1);
      check($sformatf("midgs_pulse_c%0d", i), 16'(direction), 16'h1);
    end
    tick(1);
    check("midgs_after_pulse", 16'(direction), 16'h0);
    check("midgs_move_count", move_count, 16'd1);
    btn_raw = 4'hF;
    tick(12);

    // Mid-pulse reset, button kept held through reset
    do_reset();
    btn_raw = 4'b1110;
    tick(11);
    check("midrst_pulse_c1", 16'(direction), 16'h1);
    tick(1);
    check("midrst_pulse_c2", 16'(direction), 16'h1);
    rst = 1'b1;
    tick(1);
    check("midrst_direction", 16'(direction), 16'h0);
    check("midrst_move_count", move_count, 16'd0);
    check("midrst_busy", 16'(busy), 16'h0);
    rst = 1'b0;
    tick(10);
    check("midrst_repress_wait", 16'(direction), 16'h0);
    tick(1);
    check("midrst_repress_pulse", 16'(direction), 16'h1);
    check("midrst_repress_count", move_count, 16'd1);
    btn_raw = 4'hF;
    tick(12);

    // Held bottom for 100 cycles: auto-repeat if built, otherwise one move
    do_reset();
    btn_raw     = 4'b1101;
    rises       = 0;
    first_rise  = -1;
    second_rise = -1;
    prev_dir    = 4'b0000;
    for (int i = 1; i <= 115; i++) begin
      if (i == 101) btn_raw = 4'hF;
      tick(1);
      if (direction == 4'b0010 && prev_dir == 4'b0000) begin
        rises++;
        if (first_rise < 0) first_rise = i;
        else if (second_rise < 0) second_rise = i;
      end
      prev_dir = direction;
    end
    check("hold_first_pulse", 16'(first_rise), 16'd11);
`ifdef DIR_AUTOREPEAT_EN
    check("hold_pulse_count", 16'(rises), 16'd3);
    check("hold_repeat_spacing", 16'(second_rise - first_rise), 16'd36);
    check("hold_move_count", move_count, 16'd3);
`else
    check("hold_pulse_count", 16'(rises), 16'd1);
    check("hold_move_count", move_count, 16'd1);
`endif
    check("hold_final_busy", 16'(busy), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/direction_input_ctrl.md
# direction_input_ctrl

Conditions the four raw direction push-buttons into the one-hot `direction` command consumed by `game2048`. Each input passes through a synchroniser and a debouncer. A single clean press becomes exactly one fixed-length direction pulse. Presses are accepted only while `game_state` reports playing, and the pulse is held long enough for the game FSM to go from IDLE through MOVE_MERGE.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a debounced level changes. Minimum 2.
- `PULSE_CYCLES`, default 4: cycles for which `direction` is held non-zero per accepted press. Minimum 2.
- `REPEAT_CYCLES`, default 25000000: hold time before auto-repeat. Used only with `DIR_AUTOREPEAT_EN`.
- `BTN_ACTIVE_LOW`, default 1: 1 means a raw button reads 0 when pressed.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  4  asynchronous buttons. Bit 0 top, 1 bottom, 2 left, 3 right.
- `game_state`  in  2  from `game2048`: 00 not_playing, 01 playing, 10 win, 11 lose.
- `direction`  out  4  one-hot move to `game2048`: 0001 top, 0010 bottom, 0100 left, 1000 right, 0000 none.
- `move_count`  out  16  number of accepted moves, saturating at 16'hFFFF.
- `busy`  out  1  high whenever the FSM is not in READY.

## Operation
**Input conditioning**
- Each bit is polarity-normalised to pressed = 1, then passes through a 2-flop synchroniser.
- Each bit has its own debounce counter. It increments while the synchronised value differs from the debounced value and clears when they match.
- When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, the debounced bit takes the new value and the counter clears.

**FSM states**
- READY
  - `direction`=0.
  - If `game_state`==01 and exactly one debounced bit is set: latch that one-hot code, load the pulse counter with `PULSE_CYCLES-1`, increment `move_count`, go to EMIT.
  - If `game_state`==01 and two or more bits are set: go to WAIT_RELEASE. No move is issued.
  - If `game_state`!=01: stay in READY and ignore all presses.
- EMIT
  - `direction`=latched code.
  - The pulse counter decrements each cycle. At 0, go to WAIT_RELEASE.
  - `game_state` is not sampled in EMIT, because `game2048` drives 00 during MOVE_MERGE. Button changes are also ignored.
- WAIT_RELEASE
  - `direction`=0.
  - When all debounced bits are 0, go to READY.

**Other rules**
- `move_count` saturates at 16'hFFFF and never wraps. It is not cleared by game_state changes, only by `rst`.
- `rst` mid-EMIT drops `direction` to 0 on the next edge.
- A press already held when `rst` deasserts is treated as a new press once it has been debounced.

## Timing
- Reset values:
  - `direction`=0, `move_count`=0, `busy`=0.
  - FSM in READY.
  - Synchroniser flops, debounced bits and all counters = 0 (released).
- Press latency: a raw edge sampled at edge N gives debounced=1 at edge N+1+`DEBOUNCE_CYCLES`. `direction` becomes valid at edge N+2+`DEBOUNCE_CYCLES`.
- Pulse length: `direction` is non-zero for exactly `PULSE_CYCLES` consecutive cycles.
- `move_count` updates on the same edge that `direction` first becomes non-zero.
- Back-to-back pulses without an intervening release are impossible, except for auto-repeat.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles never changes the debounced level.

## Configuration
- `DIR_AUTOREPEAT_EN` defined:
  - A repeat counter runs in WAIT_RELEASE while exactly one debounced bit is set and it equals the latched code.
  - When the counter reaches `REPEAT_CYCLES-1` and `game_state`==01, the FSM re-enters EMIT. It issues the same code and increments `move_count`.
  - The repeat counter clears on any change of the debounced bits.
- `DIR_AUTOREPEAT_EN` undefined: no repeat logic is built, and a held button yields exactly one move.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=8, `PULSE_CYCLES`=4, `REPEAT_CYCLES`=32, `BTN_ACTIVE_LOW`=1.
- Clean press: `game_state`=01, `btn_raw`=4'b1011 (left), held for 20 cycles. Expected: `direction`=0100 for exactly 4 cycles starting 10 edges after the press, `move_count`=1, then 0000 while still held.
- Bounce: bit 0 toggles every 3 cycles for 30 cycles, then settles released. Expected: `direction` stays 0000 and `move_count`=0.
- Gating: with `game_state`=11, press right. Expected: no pulse. Switch `game_state` to 01 while still held. Expected: one pulse 1000 on the next READY cycle.
- Multi-press: press top and right together (`btn_raw`=4'b0110). Expected: no pulse, `busy`=1 until both are released, then `busy`=0.
- Mid-pulse events: during EMIT, drive `game_state`=00 and assert `rst` on pulse cycle 2 in a second run. Expected: the first run completes all 4 cycles. The second run has `direction`=0, `move_count`=0 and `busy`=0 on the edge after `rst`.
- Auto-repeat, with `DIR_AUTOREPEAT_EN`: hold bottom for 100 cycles. Expected: repeated 0010 pulses spaced 32+4 cycles apart, with `move_count` incremented once per pulse. Without the macro: exactly one pulse.
